key_load_ctrl: RTL and testbench

Boot-time key provisioning controller for the hardware-locked core. It fetches the unlock key chunk-by-chunk from the tamper-protected key store over a req/ack handshake and assembles it in a shadow register. It drives the assembled key onto the lock-module key bus and holds the core (PC and downstream stages) in reset until the key is loaded. It also handles read timeouts, bounded retries, an error state and an explicit relock.

---
 rtl/key_load_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_key_load_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_load_ctrl.sv
// -----------------------------------------------------------------------------
// key_load_ctrl
//
// Boot-time key provisioning controller for the hardware-locked core. It reads
// the unlock key from the tamper-protected key store one chunk at a time over a
// req/ack handshake and assembles the chunks in a shadow register. Once every
// chunk is in, it drives the full key onto the lock-module key bus. After
// RELEASE_DLY more cycles it lets the core out of reset.
//
// A read that times out counts as a failed attempt. A read whose parity is bad
// (optional check) also counts as a failed attempt. After MAX_RETRY failed
// attempts in one load sequence the controller enters ERROR. relock discards
// the key and re-locks the core from any state.
//
// Optional feature (compile-time macro):
//   KEY_PARITY_CHK_EN : adds input nvm_par. A read is accepted only when
//                       ^{nvm_data, nvm_par} == 0. A read that fails this check
//                       is dropped and counts as a failed attempt.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   start       in   pulse, begins a key load (honoured in IDLE and ERROR only)
//   relock      in   pulse, discards the key and re-locks the core
//   nvm_req     out  key-store read request
//   nvm_addr    out  key-store read address, stable while nvm_req=1
//   nvm_ack     in   read data valid, sampled only while a read is pending
//   nvm_data    in   read data chunk
//   nvm_par     in   read data parity bit (KEY_PARITY_CHK_EN only)
//   key_out     out  assembled key, zero unless key_valid=1
//   key_valid   out  key fully loaded
//   core_rst_n  out  active-low core reset, released RELEASE_DLY after key_valid
//   busy        out  load sequence in progress
//   err         out  retries exhausted
// -----------------------------------------------------------------------------
module key_load_ctrl #(
  parameter int                KEY_WIDTH   = 8,
  parameter int                CHUNK_W     = 2,
  parameter int                ADDR_W      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 4'h0,
  parameter int                TIMEOUT_CYC = 16,
  parameter int                MAX_RETRY   = 3,
  parameter int                RELEASE_DLY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 relock,
  output logic                 nvm_req,
  output logic [ADDR_W-1:0]    nvm_addr,
  input  logic                 nvm_ack,
  input  logic [CHUNK_W-1:0]   nvm_data,
`ifdef KEY_PARITY_CHK_EN
  input  logic                 nvm_par,
`endif
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 core_rst_n,
  output logic                 busy,
  output logic                 err
);

  localparam int NUM_CHUNKS = KEY_WIDTH / CHUNK_W;
  localparam int IDX_W      = (NUM_CHUNKS  > 1) ? $clog2(NUM_CHUNKS)  : 1;
  localparam int TCNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RTRY_W     = $clog2(MAX_RETRY + 1);
  localparam int RCNT_W     = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [RTRY_W-1:0] RTRY_MAX  = RTRY_W'(MAX_RETRY);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RELEASE_DLY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               r_state;
  logic [KEY_WIDTH-1:0] r_shadow;
  logic [IDX_W-1:0]     r_idx;
  logic [RTRY_W-1:0]    r_retry;
  logic [TCNT_W-1:0]    r_tcnt;
  logic [RCNT_W-1:0]    r_rcnt;
  logic                 r_nvm_req;
  logic [ADDR_W-1:0]    r_nvm_addr;
  logic [KEY_WIDTH-1:0] r_key_out;
  logic                 r_key_valid;
  logic                 r_core_rst_n;
  logic                 r_busy;
  logic                 r_err;

  logic                 w_par_bad;
  logic                 w_good_ack;
  logic                 w_fail;
  logic [RTRY_W-1:0]    w_retry_nxt;
  logic [KEY_WIDTH-1:0] w_shadow_cap;

`ifdef KEY_PARITY_CHK_EN
  assign w_par_bad = ^{nvm_data, nvm_par};
`else
  assign w_par_bad = 1'b0;
`endif

  // A bad-parity read and a timeout take the same failed-attempt path.
  assign w_good_ack  = nvm_ack && !w_par_bad;
  assign w_fail      = (nvm_ack && w_par_bad) || (!nvm_ack && (r_tcnt == TCNT_LAST));
  assign w_retry_nxt = r_retry + RTRY_W'(1);

  // The shadow register with the chunk being acknowledged merged in. This value
  // goes to key_out on entry to DONE, so the last chunk is included without an
  // extra cycle.
  // NOTE: every signal assigned in always_comb gets a full default first, so no latch is inferred.
  always_comb begin
    w_shadow_cap = r_shadow;
    w_shadow_cap[r_idx*CHUNK_W +: CHUNK_W] = nvm_data;
  end

  // NOTE: sequential state uses non-blocking assignments only. This keeps the
  // read-then-update order independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      // NOTE: the shadow register holds key material, so it is reset along
      // with the control state and never starts with stale contents.
      r_shadow     <= '0;
      r_idx        <= '0;
      r_retry      <= '0;
      r_tcnt       <= '0;
      r_rcnt       <= '0;
      r_nvm_req    <= 1'b0;
      r_nvm_addr   <= '0;
      r_key_out    <= '0;
      r_key_valid  <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else if (relock) begin
      // relock takes priority over start and nvm_ack in every state.
      r_state      <= S_IDLE;
      r_shadow     <= '0;
      r_idx        <= '0;
      r_retry      <= '0;
      r_tcnt       <= '0;
      r_rcnt       <= '0;
      r_nvm_req    <= 1'b0;
      r_key_out    <= '0;
      r_key_valid  <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            r_state    <= S_WAIT;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_retry    <= '0;
            r_tcnt     <= '0;
            r_nvm_req  <= 1'b1;
            r_nvm_addr <= BASE_ADDR;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
          end
        end

        S_WAIT: begin
          if (w_good_ack) begin
            r_shadow  <= w_shadow_cap;
            r_tcnt    <= '0;
            r_nvm_req <= 1'b0;
            if (r_idx == IDX_LAST) begin
              r_state      <= S_DONE;
              r_key_out    <= w_shadow_cap;
              r_key_valid  <= 1'b1;
              r_busy       <= 1'b0;
              r_rcnt       <= '0;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_GAP;
            end
          end else if (w_fail) begin
            // A failed attempt keeps idx, so the same chunk is read again.
            r_tcnt    <= '0;
            r_retry   <= w_retry_nxt;
            r_nvm_req <= 1'b0;
            if (w_retry_nxt == RTRY_MAX) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end

        S_GAP: begin
          // nvm_req stays low for one cycle, so each read starts as a fresh request.
          r_state    <= S_WAIT;
          r_nvm_req  <= 1'b1;
          r_nvm_addr <= BASE_ADDR + ADDR_W'(r_idx);
        end

        S_DONE: begin
          if (!r_core_rst_n) begin
            if (r_rcnt == RCNT_LAST) begin
              r_core_rst_n <= 1'b1;
            end else begin
              r_rcnt <= r_rcnt + RCNT_W'(1);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign nvm_req    = r_nvm_req;
  assign nvm_addr   = r_nvm_addr;
  assign key_out    = r_key_out;
  assign key_valid  = r_key_valid;
  assign core_rst_n = r_core_rst_n;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_key_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_load_ctrl
//
// Directed bench for key_load_ctrl with default parameters. The key store holds
// chunks {3,0,2,2} at addresses 0..3, so the expected key is 8'b10100011.
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge, half a cycle away from the active clock edge.
// -----------------------------------------------------------------------------
module tb_key_load_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       relock;
  logic       nvm_req;
  logic [3:0] nvm_addr;
  logic       nvm_ack;
  logic [1:0] nvm_data;
  logic [7:0] key_out;
  logic       key_valid;
  logic       core_rst_n;
  logic       busy;
  logic       err;

  logic [1:0] mem [0:3];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_edges;

  localparam logic [7:0] KEY_EXP = 8'b10100011;

  always #5 clk = ~clk;

  assign nvm_data = mem[nvm_addr[1:0]];

`ifdef KEY_PARITY_CHK_EN
  logic nvm_par;
  logic bad_en = 1'b0;
  assign nvm_par = (^nvm_data) ^ (bad_en && (nvm_addr == 4'd2));
`endif

  key_load_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .relock     (relock),
    .nvm_req    (nvm_req),
    .nvm_addr   (nvm_addr),
    .nvm_ack    (nvm_ack),
    .nvm_data   (nvm_data),
`ifdef KEY_PARITY_CHK_EN
    .nvm_par    (nvm_par),
`endif
    .key_out    (key_out),
    .key_valid  (key_valid),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One active edge, then return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
  endtask

  task automatic check_locked(input string tag);
    check({tag, "_key"},   32'(key_out),    32'h0);
    check({tag, "_valid"}, 32'(key_valid),  32'h0);
    check({tag, "_crst"},  32'(core_rst_n), 32'h0);
    check({tag, "_req"},   32'(nvm_req),    32'h0);
    check({tag, "_busy"},  32'(busy),       32'h0);
  endtask

  // Bounded wait for key_valid. Returns the number of edges waited.
  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    while (!key_valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, 32'(key_valid), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem[0] = 2'd3; mem[1] = 2'd0; mem[2] = 2'd2; mem[3] = 2'd2;
    rst = 1'b1; start = 1'b0; relock = 1'b0; nvm_ack = 1'b0;
    #1;
    check_locked("rst");
    check("rst_err",  32'(err),      32'h0);
    check("rst_addr", 32'(nvm_addr), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---- normal load, ack tied high ----
    nvm_ack = 1'b1;
    pulse_start();
    check("t1_req0",  32'(nvm_req),  32'h1);
    check("t1_addr0", 32'(nvm_addr), 32'h0);
    check("t1_busy",  32'(busy),     32'h1);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e % 2 == 0) begin
        check($sformatf("t1_addr_e%0d", e), 32'(nvm_addr), 32'(e / 2));
        check($sformatf("t1_req_e%0d", e),  32'(nvm_req),  32'h1);
      end
      if (e < 7) check($sformatf("t1_valid_lo_e%0d", e), 32'(key_valid), 32'h0);
    end
    check("t1_valid",   32'(key_valid),  32'h1);
    check("t1_key",     32'(key_out),    32'(KEY_EXP));
    check("t1_busy_lo", 32'(busy),       32'h0);
    check("t1_req_lo",  32'(nvm_req),    32'h0);
    check("t1_crst_lo", 32'(core_rst_n), 32'h0);
    repeat (3) tick();
    check("t1_crst_e10", 32'(core_rst_n), 32'h0);
    tick();
    check("t1_crst_e11", 32'(core_rst_n), 32'h1);

    // start while in DONE changes nothing
    pulse_start();
    check("t1_done_start_valid", 32'(key_valid),  32'h1);
    check("t1_done_start_key",   32'(key_out),    32'(KEY_EXP));
    check("t1_done_start_crst",  32'(core_rst_n), 32'h1);
    check("t1_done_start_req",   32'(nvm_req),    32'h0);
    check("t1_done_start_busy",  32'(busy),       32'h0);

    // relock from DONE
    pulse_relock();
    check_locked("t1_relock");

    // ---- ack withheld for chunk 1 on the first attempt ----
    pulse_start();
    tick();
    check("t2_gap_req", 32'(nvm_req), 32'h0);
    nvm_ack = 1'b0;
    tick();
    check("t2_req_a1",  32'(nvm_req),  32'h1);
    check("t2_addr_a1", 32'(nvm_addr), 32'h1);
    repeat (15) tick();
    check("t2_req_hold", 32'(nvm_req), 32'h1);
    tick();
    check("t2_req_drop", 32'(nvm_req), 32'h0);
    check("t2_busy_gap", 32'(busy),    32'h1);
    check("t2_err_gap",  32'(err),     32'h0);
    nvm_ack = 1'b1;
    tick();
    check("t2_retry_req",  32'(nvm_req),  32'h1);
    check("t2_retry_addr", 32'(nvm_addr), 32'h1);
    wait_valid("t2", 20, n_edges);
    check("t2_edges", 32'(n_edges), 32'd5);
    check("t2_key",   32'(key_out), 32'(KEY_EXP));
    check("t2_err",   32'(err),     32'h0);
    pulse_relock();

    // ---- ack never returned: retries exhausted ----
    nvm_ack = 1'b0;
    pulse_start();
    n_edges = 0;
    while (!err && n_edges < 200) begin
      tick();
      n_edges++;
    end
    check("t3_err",   32'(err),     32'h1);
    check("t3_edges", 32'(n_edges), 32'd50);
    check_locked("t3_error");
    nvm_ack = 1'b1;
    pulse_start();
    check("t3_err_clr", 32'(err),      32'h0);
    check("t3_req",     32'(nvm_req),  32'h1);
    check("t3_addr",    32'(nvm_addr), 32'h0);
    wait_valid("t3", 20, n_edges);
    check("t3_load_edges", 32'(n_edges), 32'd7);
    check("t3_key",        32'(key_out), 32'(KEY_EXP));
    pulse_relock();

    // ---- relock mid-load coinciding with nvm_ack ----
    pulse_start();
    tick();
    tick();
    check("t4_req_a1",  32'(nvm_req),  32'h1);
    check("t4_addr_a1", 32'(nvm_addr), 32'h1);
    pulse_relock();
    check_locked("t4_relock");
    check("t4_err", 32'(err), 32'h0);
    tick();
    check_locked("t4_stay_idle");

    // ---- asynchronous reset between edges, mid-load ----
    pulse_start();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_locked("t5_async");
    check("t5_addr", 32'(nvm_addr), 32'h0);
    check("t5_err",  32'(err),      32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_locked("t5_after");

`ifdef KEY_PARITY_CHK_EN
    // ---- bad parity on chunk 2 first attempt ----
    pulse_start();
    repeat (4) tick();
    check("t6_addr2", 32'(nvm_addr), 32'h2);
    bad_en = 1'b1;
    tick();
    check("t6_gap_req", 32'(nvm_req),     32'h0);
    check("t6_retry",   32'(dut.r_retry), 32'h1);
    check("t6_valid",   32'(key_valid),   32'h0);
    bad_en = 1'b0;
    tick();
    check("t6_re_req",  32'(nvm_req),  32'h1);
    check("t6_re_addr", 32'(nvm_addr), 32'h2);
    wait_valid("t6", 20, n_edges);
    check("t6_edges", 32'(n_edges), 32'd3);
    check("t6_key",   32'(key_out), 32'(KEY_EXP));
    check("t6_err",   32'(err),     32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
